// File: rtl/fe_framer.sv
// fe_framer -- framing stage of the MFCC front end.
//
// Fetches 16-bit speech samples (low byte first) from the byte-wide Speech
// RAM, applies pre-emphasis p = x - x_prev + (x_prev >>> 5), multiplies by an
// unsigned Q0.8 Hamming coefficient, floors and saturates back to 16 bits, and
// writes each frame into one half of a ping-pong buffer. Overlapping frames are
// produced by re-fetching from RAM starting HOP samples after the previous
// frame's start.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   start, num_frames   start pulse (ignored while busy), frame count
//   ram_address/ram_rd  Speech RAM byte address and read strobe
//   ram_datain          RAM data, valid the cycle after ram_rd
//   win_addr/win_coef   window index and coefficient (1-cycle latency)
//   rd_en/rd_addr       consumer read port into the held bank
//   rd_data             registered read data
//   frame_start         pulse: a full frame is now held for the consumer
//   frame_done          pulse from consumer: release the held bank
//   framenum            index of the frame currently held
//   busy, frm_finish    run in progress / run complete
module fe_framer #(
  parameter int FRAME_LEN = 256,
  parameter int HOP       = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [7:0]                   num_frames,
  output logic [15:0]                  ram_address,
  output logic                         ram_rd,
  input  logic [7:0]                   ram_datain,
  output logic [$clog2(FRAME_LEN)-1:0] win_addr,
  input  logic [7:0]                   win_coef,
  input  logic                         rd_en,
  input  logic [$clog2(FRAME_LEN)-1:0] rd_addr,
  output logic [15:0]                  rd_data,
  output logic                         frame_start,
  input  logic                         frame_done,
  output logic [7:0]                   framenum,
  output logic                         busy,
  output logic                         frm_finish
);

  localparam int AW = $clog2(FRAME_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_LO, S_HI, S_CALC, S_WR, S_HANDOFF, S_DRAIN
  } state_t;

  state_t state_reg, state_next;

  logic               busy_reg, frm_finish_reg, frame_start_reg;
  logic [7:0]         framenum_reg, nf_reg, frame_reg;
  logic [15:0]        base_reg;       // sample index of the first sample of the frame being filled
  logic [AW-1:0]      i_reg;          // sample index within the frame being filled
  logic [2:0]         prime_cnt_reg;
  logic [7:0]         lo_byte_reg;
  logic signed [15:0] x_prev_reg;
  logic [15:0]        y_reg;
  logic               fill_bank_reg, held_bank_reg, held_valid_reg;
  logic [15:0]        rd_data_reg;

  logic [15:0] buf_mem [0:2*FRAME_LEN-1];

  // control strobes from the next-state logic
  logic        accept, do_handoff, release_hold, last_frame;
  logic [15:0] smp_idx, prime_idx;

  // datapath
  logic signed [15:0] x_cur, xp_sh;
  logic signed [17:0] p_val;
  logic [26:0]        w_raw;
  logic signed [26:0] w_sh;
  logic [15:0]        y_sat;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    ram_rd       = 1'b0;
    ram_address  = 16'd0;
    accept       = 1'b0;
    do_handoff   = 1'b0;
    release_hold = frame_done && held_valid_reg;
    last_frame   = (frame_reg == nf_reg - 8'd1);
    smp_idx      = base_reg + {{(16-AW){1'b0}}, i_reg};
    prime_idx    = base_reg - 16'd1;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          // frame 0 uses x_prev = 0, so it needs no prime fetch
          state_next = (num_frames == 8'd0) ? S_IDLE : S_LO;
        end
      end
      S_PRIME: begin
        if (prime_cnt_reg == 3'd0) begin
          ram_rd      = 1'b1;
          ram_address = {prime_idx[14:0], 1'b0};
        end else if (prime_cnt_reg == 3'd1) begin
          ram_rd      = 1'b1;
          ram_address = {prime_idx[14:0], 1'b1};
        end
        if (prime_cnt_reg == 3'd7) state_next = S_LO;
      end
      S_LO: begin
        ram_rd      = 1'b1;
        ram_address = {smp_idx[14:0], 1'b0};
        state_next  = S_HI;
      end
      S_HI: begin
        ram_rd      = 1'b1;
        ram_address = {smp_idx[14:0], 1'b1};
        state_next  = S_CALC;
      end
      S_CALC: state_next = S_WR;
      S_WR: begin
        if (i_reg == AW'(FRAME_LEN - 1)) state_next = S_HANDOFF;
        else                             state_next = S_LO;
      end
      S_HANDOFF: begin
        // a release in this same cycle frees the consumer side first
        if (!held_valid_reg || frame_done) begin
          do_handoff = 1'b1;
          state_next = last_frame ? S_DRAIN : S_PRIME;
        end
      end
      S_DRAIN: begin
        if (release_hold) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pre-emphasis and window. ram_datain carries the high byte during CALC and
  // win_addr has been stable since LO, so win_coef is valid here as well.
  always_comb begin
    x_cur = {ram_datain, lo_byte_reg};
    xp_sh = x_prev_reg >>> 5;
    p_val = {{2{x_cur[15]}}, x_cur} - {{2{x_prev_reg[15]}}, x_prev_reg}
          + {{2{xp_sh[15]}}, xp_sh};
    // sign-extended operands make the unsigned 27-bit product equal the signed one
    w_raw = {{9{p_val[17]}}, p_val} * {19'd0, win_coef};
    w_sh  = $signed(w_raw) >>> 8;
    if (w_sh > 27'sd32767)       y_sat = 16'h7FFF;
    else if (w_sh < -27'sd32768) y_sat = 16'h8000;
    else                         y_sat = w_sh[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg        <= 1'b0;
      frm_finish_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      framenum_reg    <= 8'd0;
      nf_reg          <= 8'd0;
      frame_reg       <= 8'd0;
      base_reg        <= 16'd0;
      i_reg           <= '0;
      prime_cnt_reg   <= 3'd0;
      lo_byte_reg     <= 8'd0;
      x_prev_reg      <= 16'sd0;
      y_reg           <= 16'd0;
      fill_bank_reg   <= 1'b0;
      held_bank_reg   <= 1'b0;
      held_valid_reg  <= 1'b0;
    end else begin
      frame_start_reg <= 1'b0;
      if (release_hold) held_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            nf_reg        <= num_frames;
            frame_reg     <= 8'd0;
            base_reg      <= 16'd0;
            i_reg         <= '0;
            prime_cnt_reg <= 3'd0;
            x_prev_reg    <= 16'sd0;
            fill_bank_reg <= 1'b0;
            busy_reg      <= (num_frames != 8'd0);
            frm_finish_reg <= (num_frames == 8'd0);
          end
        end
        S_PRIME: begin
          prime_cnt_reg <= prime_cnt_reg + 3'd1;
          if (prime_cnt_reg == 3'd1) lo_byte_reg <= ram_datain;
          if (prime_cnt_reg == 3'd2) x_prev_reg  <= {ram_datain, lo_byte_reg};
        end
        S_HI: lo_byte_reg <= ram_datain;
        S_CALC: begin
          y_reg      <= y_sat;
          x_prev_reg <= x_cur;
        end
        S_WR: i_reg <= i_reg + 1'b1;
        S_HANDOFF: begin
          if (do_handoff) begin
            held_valid_reg  <= 1'b1;
            held_bank_reg   <= fill_bank_reg;
            frame_start_reg <= 1'b1;
            framenum_reg    <= frame_reg;
            fill_bank_reg   <= ~fill_bank_reg;
            frame_reg       <= frame_reg + 8'd1;
            base_reg        <= base_reg + 16'(HOP);
            prime_cnt_reg   <= 3'd0;
          end
        end
        S_DRAIN: begin
          if (release_hold) begin
            busy_reg       <= 1'b0;
            frm_finish_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ping-pong buffer: bank select is the top address bit
  always_ff @(posedge clk) begin
    if (!reset && state_reg == S_WR) buf_mem[{fill_bank_reg, i_reg}] <= y_reg;
  end

  always_ff @(posedge clk) begin
    if (reset)      rd_data_reg <= 16'd0;
    else if (rd_en) rd_data_reg <= buf_mem[{held_bank_reg, rd_addr}];
  end

  assign win_addr    = i_reg;
  assign rd_data     = rd_data_reg;
  assign frame_start = frame_start_reg;
  assign framenum    = framenum_reg;
  assign busy        = busy_reg;
  assign frm_finish  = frm_finish_reg;

endmodule

// File: tb/tb_fe_framer.sv
// tb_fe_framer -- directed sequence with randomized RAM/window contents,
// checked against an arithmetic model of the framing rules.
module tb_fe_framer;

  localparam int FL  = 256;
  localparam int HOP = 128;

  logic        clk = 1'b0;
  logic        reset, start, rd_en, frame_done;
  logic [7:0]  num_frames, ram_datain, win_coef, rd_addr, win_addr, framenum;
  logic [15:0] ram_address, rd_data;
  logic        ram_rd, frame_start, busy, frm_finish;

  logic [7:0] mem  [0:65535];
  logic [7:0] coef [0:FL-1];

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int fs_cnt = 0;

  always #5 clk = ~clk;

  fe_framer #(.FRAME_LEN(FL), .HOP(HOP)) dut (
    .clk(clk), .reset(reset), .start(start), .num_frames(num_frames),
    .ram_address(ram_address), .ram_rd(ram_rd), .ram_datain(ram_datain),
    .win_addr(win_addr), .win_coef(win_coef), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_start(frame_start), .frame_done(frame_done),
    .framenum(framenum), .busy(busy), .frm_finish(frm_finish)
  );

  // Speech RAM and window ROM, both one cycle of read latency
  always @(posedge clk) begin
    if (ram_rd) ram_datain <= mem[ram_address];
    win_coef <= coef[win_addr];
  end

  // event counters sampled at the active edge (values of the previous cycle)
  always @(posedge clk) begin
    if (ram_rd)      rd_cnt <= rd_cnt + 1;
    if (frame_start) fs_cnt <= fs_cnt + 1;
  end

  // ---------------- reference model ----------------
  function automatic int smp(int n);
    logic [15:0] v;
    v = {mem[(2*n+1) & 65535], mem[(2*n) & 65535]};
    return int'($signed(v));
  endfunction

  function automatic logic [15:0] exp_y(int f, int i);
    int n, x, xp, p, w, y;
    n  = f*HOP + i;
    x  = smp(n);
    xp = (n == 0) ? 0 : smp(n-1);
    p  = x - xp + (xp >>> 5);
    w  = p * int'(coef[i]);
    y  = w >>> 8;
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return 16'(y);
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] nf);
    num_frames = nf;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_done();
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  task automatic wait_fs(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      if (frame_start === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_frame_start_seen"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic rd1(input int a, output logic [15:0] d);
    rd_en = 1'b1;
    rd_addr = 8'(a);
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data;
  endtask

  task automatic read_check(input int f);
    int bad;
    bad = 0;
    for (int a = 0; a < FL; a++) begin
      rd_en = 1'b1;
      rd_addr = 8'(a);
      @(negedge clk);
      if (rd_data !== exp_y(f, a)) begin
        if (bad == 0) chk($sformatf("frame%0d_rd_data[%0d]", f, a), {16'd0, rd_data}, {16'd0, exp_y(f, a)});
        bad++;
      end
    end
    rd_en = 1'b0;
    $display("[TB] frame %0d read back, %0d sample(s) differ from model", f, bad);
    chk($sformatf("frame%0d_bad_samples", f), bad, 0);
  endtask

  task automatic rand_fill();
    for (int k = 0; k < 4096; k++) mem[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < FL; k++) coef[k] = 8'($urandom_range(0, 255));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_frm_finish"}, {31'd0, frm_finish}, 32'd0);
    chk({tag, "_frame_start"}, {31'd0, frame_start}, 32'd0);
    chk({tag, "_ram_rd"}, {31'd0, ram_rd}, 32'd0);
    chk({tag, "_ram_address"}, {16'd0, ram_address}, 32'd0);
    chk({tag, "_framenum"}, {24'd0, framenum}, 32'd0);
    chk({tag, "_win_addr"}, {24'd0, win_addr}, 32'd0);
    chk({tag, "_rd_data"}, {16'd0, rd_data}, 32'd0);
  endtask

  logic [15:0] d;
  int base_fs, base_rd, stall_rd;

  initial begin
    reset = 1'b1; start = 1'b0; num_frames = 8'd0; rd_en = 1'b0;
    rd_addr = 8'd0; frame_done = 1'b0; ram_datain = 8'd0; win_coef = 8'd0;
    for (int k = 0; k < 65536; k++) mem[k] = 8'd0;
    for (int k = 0; k < FL; k++) coef[k] = 8'd0;
    tick(3);
    chk_idle_outputs("reset");
    reset = 1'b0;
    tick(2);

    // 1: reset mid-fill, then a clean restart from address 0
    rand_fill();
    do_start(8'd1);
    chk("t1_busy_after_start", {31'd0, busy}, 32'd1);
    tick(300);
    base_fs = fs_cnt;
    reset = 1'b1;
    tick(2);
    chk_idle_outputs("t1_reset");
    reset = 1'b0;
    tick(5);
    chk("t1_no_partial_frame_start", fs_cnt, base_fs);
    do_start(8'd1);
    chk("t1_restart_ram_rd", {31'd0, ram_rd}, 32'd1);
    chk("t1_restart_addr", {16'd0, ram_address}, 32'd0);
    wait_fs("t1");
    chk("t1_framenum", {24'd0, framenum}, 32'd0);
    read_check(0);
    pulse_done();
    chk("t1_frm_finish", {31'd0, frm_finish}, 32'd1);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    $display("[TB] test 1 reset/restart done");

    // 2: constant 0x0100 samples, full-scale window
    for (int k = 0; k < 1024; k++) begin mem[2*k] = 8'h00; mem[2*k+1] = 8'h01; end
    for (int k = 0; k < FL; k++) coef[k] = 8'd255;
    base_fs = fs_cnt;
    do_start(8'd1);
    wait_fs("t2");
    read_check(0);
    rd1(0, d); chk("t2_rd_data0", {16'd0, d}, 32'd255);
    rd1(5, d); chk("t2_rd_data5", {16'd0, d}, 32'd7);
    pulse_done();
    tick(3);
    chk("t2_frame_start_count", fs_cnt - base_fs, 1);
    $display("[TB] test 2 constant input done");

    // 3: saturation with alternating extremes
    for (int k = 0; k < 1024; k++) begin
      mem[2*k]   = (k % 2 == 0) ? 8'hFF : 8'h00;
      mem[2*k+1] = (k % 2 == 0) ? 8'h7F : 8'h80;
    end
    do_start(8'd1);
    wait_fs("t3");
    read_check(0);
    rd1(1, d); chk("t3_rd_data1", {16'd0, d}, 32'h8000);
    rd1(2, d); chk("t3_rd_data2", {16'd0, d}, 32'h7FFF);
    pulse_done();
    $display("[TB] test 3 saturation done");

    // 4: two overlapping frames; a second start while busy is ignored
    rand_fill();
    base_fs = fs_cnt;
    do_start(8'd2);
    tick(5);
    do_start(8'd0);
    chk("t4_start_ignored_busy", {31'd0, busy}, 32'd1);
    chk("t4_start_ignored_finish", {31'd0, frm_finish}, 32'd0);
    wait_fs("t4_f0");
    chk("t4_framenum0", {24'd0, framenum}, 32'd0);
    for (int c = 0; c < 20 && ram_rd !== 1'b1; c++) @(negedge clk);
    chk("t4_prime_addr", {16'd0, ram_address}, 32'd254);
    read_check(0);
    pulse_done();
    wait_fs("t4_f1");
    chk("t4_framenum1", {24'd0, framenum}, 32'd1);
    read_check(1);
    pulse_done();
    chk("t4_frm_finish", {31'd0, frm_finish}, 32'd1);
    chk("t4_busy_end", {31'd0, busy}, 32'd0);
    tick(2);
    chk("t4_frame_start_count", fs_cnt - base_fs, 2);
    $display("[TB] test 4 overlap done");

    // 5: back-pressure with three frames
    rand_fill();
    do_start(8'd3);
    wait_fs("t5_f0");
    read_check(0);
    tick(1000);
    base_fs = fs_cnt;
    stall_rd = 0;
    for (int c = 0; c < 16; c++) begin
      if (ram_rd === 1'b1) stall_rd++;
      @(negedge clk);
    end
    chk("t5_stall_no_ram_rd", stall_rd, 0);
    chk("t5_stall_no_frame_start", fs_cnt, base_fs);
    pulse_done();
    chk("t5_release_frame_start", {31'd0, frame_start}, 32'd1);
    chk("t5_release_framenum", {24'd0, framenum}, 32'd1);
    read_check(1);
    pulse_done();
    wait_fs("t5_f2");
    chk("t5_framenum2", {24'd0, framenum}, 32'd2);
    read_check(2);
    pulse_done();
    chk("t5_frm_finish", {31'd0, frm_finish}, 32'd1);
    $display("[TB] test 5 back-pressure done");

    // 6: zero frames
    tick(2);
    base_rd = rd_cnt;
    base_fs = fs_cnt;
    do_start(8'd0);
    chk("t6_frm_finish", {31'd0, frm_finish}, 32'd1);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    tick(10);
    chk("t6_no_ram_rd", rd_cnt, base_rd);
    chk("t6_no_frame_start", fs_cnt, base_fs);
    $display("[TB] test 6 zero frames done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
